receiver: RTL
=============

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, default 4, destination-address field width; DATA_SIZE, default 32, payload width; PORTS_NUM, default 4, network ports, with port index PORTS_NUM being the local port; FIFO_DEPTH, default 8, flit storage entries, a power of 2 and at least 2.
REQ-002 Local constant BUS_SIZE SHALL equal DATA_SIZE+ADDR_SIZE+1. Flit layout: [ADDR_SIZE-1:0] is the destination address, bit [ADDR_SIZE] is the tail flag, and the upper DATA_SIZE bits are the payload.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 a_rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_ready_in  input  PORTS_NUM+1  per-port "flit valid" from the upstream senders.
REQ-006 data_i  input  BUS_SIZE*(PORTS_NUM+1)  per-port flits; port p occupies [p*BUS_SIZE +: BUS_SIZE].
REQ-007 mem_readed  input  1  pop request from the downstream transceiver.
REQ-008 r_ready_out  output  PORTS_NUM+1  per-port accept pulse to the senders.
REQ-009 data_o  output  BUS_SIZE  head-of-FIFO flit, first-word-fall-through.
REQ-010 mem_empty  output  1  high when the FIFO holds 0 flits.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored flits.

Function
REQ-012 A port SHALL request only when its wr_ready_in bit is exactly 1; X and Z (unconnected port) SHALL count as no request.
REQ-013 The state machine SHALL have the states IDLE, LOCKED and ACK.
REQ-014 IDLE: when the FIFO is not full and at least one port requests, the block SHALL pick the first requesting port in round-robin order starting at rr_ptr.
- On that edge it writes that port's flit, sets r_ready_out[p]=1, records lock_port=p, sets rr_ptr=(p+1) mod (PORTS_NUM+1), and goes to ACK.
REQ-015 ACK SHALL last exactly 1 cycle.
- r_ready_out returns to all-zero.
- Requests from every port are ignored.
- Next state is IDLE if the last written flit had its tail flag set, otherwise LOCKED.
REQ-016 LOCKED: only lock_port SHALL be served.
- When wr_ready_in[lock_port]==1 and the FIFO is not full, the flit is written, r_ready_out[lock_port] is pulsed, and the state goes to ACK.
- Other ports wait, so packets are never interleaved.
REQ-017 r_ready_out SHALL be one-hot or zero and SHALL never be high for 2 consecutive cycles.
REQ-018 Accept-to-pulse latency SHALL be 0 cycles: the pulse is registered on the same edge as the write. The FIFO write becomes visible on data_o and mem_empty in the following cycle.
REQ-019 Pop: on an edge with mem_readed==1 and the FIFO not empty, the read pointer SHALL advance by 1. mem_readed while empty SHALL be ignored, with no pointer or count change.
REQ-020 Full SHALL be evaluated from fifo_count before any same-cycle pop. No write occurs when fifo_count==FIFO_DEPTH, and the sender's wr_ready stays pending.
REQ-021 A simultaneous write and pop SHALL leave fifo_count unchanged, with both pointers advancing.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-023 data_o SHALL equal storage[rd_ptr] combinationally. Its value while mem_empty=1 is don't-care, except immediately after reset (REQ-025).

Reset
REQ-024 a_rst=1 SHALL immediately force: state=IDLE, rr_ptr=0, lock_port=0, rd_ptr=wr_ptr=0, fifo_count=0, mem_empty=1, r_ready_out=0.
REQ-025 Reset SHALL clear all storage, so data_o=0 after reset.
REQ-026 Reset in the middle of a packet SHALL discard the partial packet and the lock; the first post-reset accept follows IDLE rules.

Verification
REQ-027 Single-flit packet: port 2 presents addr=5 with the tail flag set -> r_ready_out=5'b00100 for 1 cycle; the next cycle mem_empty=0, data_o equals the flit, and the state is IDLE.
REQ-028 Lock: port 0 sends a 3-flit packet while port 1 requests continuously -> all 3 port-0 flits are stored before any port-1 flit, and r_ready_out[1]=0 throughout.
REQ-029 Round-robin: ports 0, 1 and 3 request single-flit packets simultaneously from reset -> accept order is 0, 1, 3; rr_ptr=4 afterwards.
REQ-030 Full and back-pressure, FIFO_DEPTH=8: 8 flits stored with no pops -> fifo_count=8, the 9th request gets no pulse; one mem_readed pulse -> the 9th flit is accepted the cycle after, and fifo_count returns to 8.
REQ-031 Wrap and concurrency: 20 flits pushed while mem_readed is held high -> output order matches input order, and fifo_count stays at or below 1.
REQ-032 Reset mid-packet, plus robustness: a_rst asserted after flit 2 of 4 -> all outputs take their reset values immediately; a Z input on wr_ready_in[4] -> never accepted.

Source files
------------

// File: rtl/receiver.sv
// receiver: collects flits from PORTS_NUM+1 upstream senders into one FIFO.
//
// A round-robin arbiter picks a requesting port when idle. Once a packet has
// started, the chosen port stays locked until a flit with the tail flag is
// written, so packets from different ports never interleave. Every accepted
// flit is followed by a one-cycle ACK state, which keeps r_ready_out from
// being high on two consecutive cycles.
//
// Ports:
//   clk          clock, rising edge
//   a_rst        asynchronous reset, active high
//   wr_ready_in  per-port flit valid; only a clean 1 counts as a request
//   data_i       per-port flits, port p at [p*BUS_SIZE +: BUS_SIZE]
//   mem_readed   pop request from the downstream consumer
//   r_ready_out  per-port accept pulse, one-hot or zero
//   data_o       head-of-FIFO flit (first-word-fall-through)
//   mem_empty    FIFO holds no flits
//   fifo_count   number of stored flits
//
// Flit layout: [ADDR_SIZE-1:0] address, [ADDR_SIZE] tail, upper bits payload.
//
// state  | meaning
// IDLE   | no packet in progress, arbitrate round-robin from rr_ptr
// LOCKED | mid-packet, only lock_port may write
// ACK    | one cycle after a write, all requests ignored
module receiver #(
    parameter int ADDR_SIZE  = 4,
    parameter int DATA_SIZE  = 32,
    parameter int PORTS_NUM  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                            clk,
    input  logic                                            a_rst,
    input  logic [PORTS_NUM:0]                              wr_ready_in,
    input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0] data_i,
    input  logic                                            mem_readed,
    output logic [PORTS_NUM:0]                              r_ready_out,
    output logic [DATA_SIZE+ADDR_SIZE:0]                    data_o,
    output logic                                            mem_empty,
    output logic [$clog2(FIFO_DEPTH):0]                     fifo_count
);

    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int NP       = PORTS_NUM + 1;
    localparam int PW       = (NP > 1) ? $clog2(NP) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state, next_state;
    logic [PW-1:0]       rr_ptr, lock_port;
    logic                last_tail;

    logic [BUS_SIZE-1:0] storage [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr, wr_ptr;

    logic [NP-1:0]       req;
    logic                grant_found;
    logic [PW-1:0]       grant_port;
    int                  rr_cand;
    logic                wr_en;
    logic [PW-1:0]       wr_port;
    logic [BUS_SIZE-1:0] wr_flit;
    logic [NP-1:0]       wr_onehot;
    logic                full, pop;

    // Undriven (X/Z) request lines must never look like a request.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            req[p] = (wr_ready_in[p] === 1'b1);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_port  = '0;
        rr_cand     = 0;
        for (int i = 0; i < NP; i++) begin
            rr_cand = int'(rr_ptr) + i;
            if (rr_cand >= NP) begin
                rr_cand = rr_cand - NP;
            end
            if (!grant_found && req[PW'(rr_cand)]) begin
                grant_found = 1'b1;
                grant_port  = PW'(rr_cand);
            end
        end
    end

    assign full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop  = mem_readed && (fifo_count != '0);

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_port    = lock_port;
        case (state)
            IDLE: begin
                if (!full && grant_found) begin
                    wr_en      = 1'b1;
                    wr_port    = grant_port;
                    next_state = ACK;
                end
            end
            LOCKED: begin
                if (!full && req[lock_port]) begin
                    wr_en      = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = last_tail ? IDLE : LOCKED;
            end
            default: next_state = IDLE;
        endcase
    end

    assign wr_flit   = data_i[wr_port*BUS_SIZE +: BUS_SIZE];
    assign wr_onehot = NP'(1) << wr_port;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lock_port   <= '0;
            last_tail   <= 1'b0;
            r_ready_out <= '0;
        end else begin
            state       <= next_state;
            r_ready_out <= wr_en ? wr_onehot : '0;
            if (wr_en) begin
                lock_port <= wr_port;
                last_tail <= wr_flit[ADDR_SIZE];
                if (state == IDLE) begin
                    rr_ptr <= (wr_port == PW'(PORTS_NUM)) ? '0 : wr_port + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                storage[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                storage[wr_ptr] <= wr_flit;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign data_o    = storage[rd_ptr];
    assign mem_empty = (fifo_count == '0);

endmodule
